// File: rtl/program_loader.sv
// program_loader - boot loader: streams LEN/data/CSUM frame into memory, then releases the CPU
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [DATA_W-1:0] DEPTH_D = DATA_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    len;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   sum_next;
    logic                accept;
    logic                last_data;

    // start pre-empts any byte offered in the same cycle, so it is never consumed
    assign accept    = in_valid && in_ready && !start;
    assign sum_next  = sum + in_data;
    assign last_data = (cnt + CNT_W'(1)) == len;

    always_comb begin
        state_n  = state;
        in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
        if (start) begin
            state_n = S_LEN;
        end else begin
            case (state)
                S_LEN: begin
                    if (accept) begin
                        if (in_data == '0 || in_data > DEPTH_D)
                            state_n = S_ERR;
                        else
                            state_n = S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept && last_data)
                        state_n = S_CSUM;
                end
                S_CSUM: begin
                    if (accept)
                        state_n = (sum_next == '0) ? S_DONE : S_ERR;
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            len       <= '0;
            cnt       <= '0;
            sum       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_run   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_n;
            mem_we    <= 1'b0;
            // status flags track the state being entered so they line up with it
            cpu_run   <= (state_n == S_DONE);
            load_done <= (state_n == S_DONE) && (state != S_DONE);
            load_err  <= (state_n == S_ERR);
            if (start) begin
                len <= '0;
                cnt <= '0;
                sum <= '0;
            end else if (accept) begin
                case (state)
                    S_LEN: begin
                        len <= CNT_W'(in_data);
                        cnt <= '0;
                        sum <= in_data;
                    end
                    S_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt[ADDR_W-1:0];
                        mem_wdata <= in_data;
                        cnt       <= cnt + CNT_W'(1);
                        sum       <= sum_next;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - table-driven and randomized checks of program_loader against a frame model
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_run;
    logic       load_done;
    logic       load_err;

    program_loader #(.ADDR_W(5), .DATA_W(8), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] frame [0:39];
    int         wr_n = 0;
    logic [4:0] wr_addr [0:63];
    logic [7:0] wr_data [0:63];
    int         done_cnt = 0;
    int         bad_run = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
            end
            wr_n = wr_n + 1;
        end
        if (load_done) done_cnt = done_cnt + 1;
        if (cpu_run && in_ready) bad_run = bad_run + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_n = 0;
        done_cnt = 0;
        bad_run = 0;
    endtask

    // pulse start, then confirm the loader sits in LEN with status cleared
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear_log();
        chk("start_in_ready", in_ready, 1);
        chk("start_load_err", load_err, 0);
        chk("start_cpu_run", cpu_run, 0);
    endtask

    // offer frame[0..n-1]; gaps randomly drop in_valid; returns at a negedge after last accept
    task automatic send(input int n, input bit gaps);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < n && guard < 2000) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = frame[idx];
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        if (idx < n) chk("send_timeout", idx, n);
    endtask

    // expected effect of a frame: writes are data bytes at addresses 0..nwr-1
    task automatic check_frame(input bit ok, input int nwr);
        repeat (3) @(negedge clk);
        chk("num_writes", wr_n, nwr);
        for (int i = 0; i < nwr && i < wr_n && i < 64; i++) begin
            chk("wr_addr", int'(wr_addr[i]), i);
            chk("wr_data", int'(wr_data[i]), int'(frame[1+i]));
        end
        chk("done_pulses", done_cnt, ok ? 1 : 0);
        chk("cpu_run", cpu_run, ok ? 1 : 0);
        chk("load_err", load_err, ok ? 0 : 1);
        chk("in_ready_end", in_ready, 0);
        chk("run_while_loading", bad_run, 0);
    endtask

    typedef struct {
        int         n;
        logic [7:0] b [0:7];
        bit         ok;
        int         nwr;
    } vec_t;

    vec_t tbl [0:5];

    initial begin
        tbl[0] = '{5, '{8'h03, 8'h20, 8'hA1, 8'hC4, 8'h78, 8'h00, 8'h00, 8'h00}, 1'b1, 3};
        tbl[1] = '{5, '{8'h03, 8'h20, 8'hA1, 8'hC4, 8'h77, 8'h00, 8'h00, 8'h00}, 1'b0, 3};
        tbl[2] = '{1, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 0};
        tbl[3] = '{1, '{8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 0};
        tbl[4] = '{3, '{8'h01, 8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1};
        tbl[5] = '{3, '{8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_load_err", load_err, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 8; k++) frame[k] = tbl[t].b[k];
            do_start();
            send(tbl[t].n, t[0]);
            check_frame(tbl[t].ok, tbl[t].nwr);
        end

        // randomized frames against the arithmetic frame model
        for (int r = 0; r < 14; r++) begin
            int L, s, nconsume, nwr;
            bit ok;
            L = (r == 0) ? 32 : int'($urandom_range(1, 32));
            if (r % 5 == 4) L = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 255));
            frame[0] = 8'(L);
            s = L;
            for (int i = 0; i < 32 && i < L; i++) begin
                frame[1+i] = 8'($urandom_range(0, 255));
                s += frame[1+i];
            end
            if (L >= 1 && L <= 32) begin
                frame[L+1] = 8'((256 - (s % 256)) % 256);
                if (r != 0 && $urandom_range(0, 2) == 0)
                    frame[L+1] = frame[L+1] + 8'($urandom_range(1, 255));
                ok = ((s + frame[L+1]) % 256) == 0;
                nconsume = L + 2;
                nwr = L;
            end else begin
                ok = 1'b0;
                nconsume = 1;
                nwr = 0;
            end
            do_start();
            send(nconsume, 1'b1);
            check_frame(ok, nwr);
        end

        // start during DATA after 2 of 5 bytes; byte offered with start is dropped
        frame[0] = 8'h05; frame[1] = 8'h11; frame[2] = 8'h22;
        do_start();
        send(3, 1'b0);
        start = 1'b1; in_valid = 1'b1; in_data = 8'h99;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        clear_log();
        chk("restart_in_ready", in_ready, 1);
        chk("restart_load_err", load_err, 0);
        chk("restart_cpu_run", cpu_run, 0);
        frame[0] = 8'h01; frame[1] = 8'h55; frame[2] = 8'hAA;
        send(3, 1'b0);
        check_frame(1'b1, 1);

        // asynchronous reset mid-DATA
        frame[0] = 8'h05; frame[1] = 8'h3C; frame[2] = 8'h4D;
        do_start();
        send(3, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_mem_we", mem_we, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_wdata", mem_wdata, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_cpu_run", cpu_run, 0);
        chk("arst_load_done", load_done, 0);
        chk("arst_load_err", load_err, 0);
        @(negedge clk);
        rst = 1'b1;
        clear_log();
        in_valid = 1'b1; in_data = 8'h66;
        repeat (4) @(negedge clk);
        chk("post_rst_in_ready", in_ready, 0);
        chk("post_rst_writes", wr_n, 0);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
